// File: rtl/alu_arbiter_if.sv
// Bundles the requester-side and ALU-side signals of the two-port ALU arbiter.
// Latency: none; this is wiring only.
// Backpressure: none here; requests are level-held until ack, and the ALU paces itself through alu_done.
//
// Signals:
//   requester side : req0/req1, ir0/ir1, a0/b0, a1/b1 (to arbiter);
//                    ack, rsp_data, rsp_carry, rsp_over, rsp_err, busy (from arbiter)
//   ALU side       : alu_start, alu_ir, alu_a, alu_b, alu_oe (from arbiter);
//                    alu_done, alu_out, alu_carry, alu_over (to arbiter)
// Modports: slave = the arbiter itself, master = the environment that drives the requesters and the ALU.
interface alu_arbiter_if;
    // requester 0 / 1
    logic        req0;
    logic        req1;
    logic [7:0]  ir0;
    logic [7:0]  ir1;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [15:0] a1;
    logic [15:0] b1;

    // response back to the requesters
    logic [1:0]  ack;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_over;
    logic        rsp_err;
    logic        busy;

    // ALU control and operands
    logic        alu_start;
    logic [7:0]  alu_ir;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_oe;

    // ALU status and result
    logic        alu_done;
    logic [15:0] alu_out;
    logic        alu_carry;
    logic        alu_over;

    modport slave (
        input  req0, req1, ir0, ir1, a0, b0, a1, b1,
        input  alu_done, alu_out, alu_carry, alu_over,
        output ack, rsp_data, rsp_carry, rsp_over, rsp_err, busy,
        output alu_start, alu_ir, alu_a, alu_b, alu_oe
    );

    modport master (
        output req0, req1, ir0, ir1, a0, b0, a1, b1,
        output alu_done, alu_out, alu_carry, alu_over,
        input  ack, rsp_data, rsp_carry, rsp_over, rsp_err, busy,
        input  alu_start, alu_ir, alu_a, alu_b, alu_oe
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter giving two requesters turns on one multi-cycle ALU with a done-low/done-high handshake.
// Latency: ack 4 + (cycles alu_done stays high after start) + (cycles it stays low) after grant; TIMEOUT cycles per wait phase max.
// Backpressure: requests are level-held until ack; one operation in flight, later requests wait for IDLE arbitration.
//
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   asynchronous active-high reset
//   bus   alu_arbiter_if.slave: requester inputs, ack/rsp_*/busy outputs, ALU start/operands/oe outputs,
//         ALU done/result/flag inputs
module alu_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    // Timer is at least 8 bits and always wide enough to reach TIMEOUT-1.
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_MAX  = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        CAPTURE = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t        state;
    logic          last_grant;   // requester served most recently
    logic          owner;        // requester whose operation is in flight
    logic          err;          // last operation ended by timeout
    logic [TW-1:0] timer;

    logic          winner;
    logic [1:0]    owner_ack;
    logic [TW-1:0] timer_inc;
    logic          timer_expired;

    // The error flag is a flop and is only ever read together with ack.
    assign bus.rsp_err = err;

    // Winner selection: a lone requester always wins; under contention the
    // requester that was not served last goes next.
    always_comb begin
        winner = 1'b0;
        if (bus.req0 && bus.req1) begin
            winner = ~last_grant;
        end else if (bus.req1) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        owner_ack     = owner ? 2'b10 : 2'b01;
        // Saturate rather than wrap so a huge TIMEOUT can never alias back to zero.
        timer_inc     = (timer == TIMER_MAX) ? timer : timer + TW'(1);
        timer_expired = (timer == TIMER_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            timer         <= '0;
            err           <= 1'b0;
            bus.ack       <= 2'b00;
            bus.busy      <= 1'b0;
            bus.alu_start <= 1'b0;
            bus.alu_oe    <= 1'b0;
            bus.alu_ir    <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_over  <= 1'b0;
        end else begin
            // Single-cycle strobes fall back to zero unless a transition below raises them.
            bus.alu_start <= 1'b0;
            bus.alu_oe    <= 1'b0;
            bus.ack       <= 2'b00;

            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        // Operands are copied here so the requester may change
                        // them later without disturbing the operation.
                        owner         <= winner;
                        last_grant    <= winner;
                        bus.alu_ir    <= winner ? bus.ir1 : bus.ir0;
                        bus.alu_a     <= winner ? bus.a1  : bus.a0;
                        bus.alu_b     <= winner ? bus.b1  : bus.b0;
                        bus.alu_start <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= ISSUE;
                    end
                end

                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_LO;
                end

                // The ALU acknowledges start by dropping done.
                WAIT_LO: begin
                    if (!bus.alu_done) begin
                        timer <= '0;
                        state <= WAIT_HI;
                    end else if (timer_expired) begin
                        err     <= 1'b1;
                        bus.ack <= owner_ack;
                        state   <= RESP;
                    end else begin
                        timer <= timer_inc;
                    end
                end

                // Done rising again means the result is ready to be enabled.
                WAIT_HI: begin
                    if (bus.alu_done) begin
                        bus.alu_oe <= 1'b1;
                        state      <= CAPTURE;
                    end else if (timer_expired) begin
                        err     <= 1'b1;
                        bus.ack <= owner_ack;
                        state   <= RESP;
                    end else begin
                        timer <= timer_inc;
                    end
                end

                // alu_oe is high during this cycle, so alu_out is valid to sample.
                CAPTURE: begin
                    bus.rsp_data  <= bus.alu_out;
                    bus.rsp_carry <= bus.alu_carry;
                    bus.rsp_over  <= bus.alu_over;
                    err           <= 1'b0;
                    bus.ack       <= owner_ack;
                    state         <= RESP;
                end

                // ack is visible during this cycle; IDLE follows so the next
                // request can be granted straight away.
                RESP: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    alu_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // ALU behaviour for the next operation: cycles done stays high after start, then cycles low.
    int cfg_h = 0;
    int cfg_l = 1;

    // Reference ALU: {over, carry, data}. Upper nibble 2 subtracts, everything else adds.
    function automatic logic [17:0] alu_fn(input logic [7:0] ir, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic        v;
        if (ir[7:4] == 4'h2) begin
            s = {1'b0, a} - {1'b0, b};
            v = (a[15] != b[15]) && (s[15] != a[15]);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            v = (a[15] == b[15]) && (s[15] != a[15]);
        end
        return {v, s[16], s[15:0]};
    endfunction

    // ALU model: reacts to alu_start, holds done high cfg_h cycles, low cfg_l cycles, then
    // raises done with the result. Shows junk on alu_out while working.
    initial begin : alu_model
        int          hc;
        int          lc;
        bit          active;
        logic [17:0] res;
        hc = 0; lc = 0; active = 0; res = '0;
        bus.alu_done  = 1'b1;
        bus.alu_out   = '0;
        bus.alu_carry = 1'b0;
        bus.alu_over  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active       = 0;
                bus.alu_done = 1'b1;
            end else if (bus.alu_start) begin
                active        = 1;
                hc            = cfg_h;
                lc            = cfg_l;
                res           = alu_fn(bus.alu_ir, bus.alu_a, bus.alu_b);
                bus.alu_done  = 1'b1;
                bus.alu_out   = 16'($urandom);
                bus.alu_carry = ~res[16];
                bus.alu_over  = ~res[17];
            end else if (active) begin
                if (hc > 0) begin
                    bus.alu_done = 1'b1;
                    hc--;
                end else if (lc > 0) begin
                    bus.alu_done = 1'b0;
                    lc--;
                end else begin
                    bus.alu_done = 1'b1;
                    {bus.alu_over, bus.alu_carry, bus.alu_out} = res;
                    active = 0;
                end
            end
        end
    end

    // Waits from the grant cycle for ack; lat = cycles from grant to ack, -1 if none within budget.
    task automatic wait_ack(output logic [1:0] ackv, output int lat, output int n_start, output int n_oe);
        ackv = 2'b00; lat = -1; n_start = 0; n_oe = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (bus.alu_start === 1'b1) n_start++;
            if (bus.alu_oe === 1'b1) n_oe++;
            if (bus.ack !== 2'b00) begin
                ackv = bus.ack;
                lat  = n;
                break;
            end
        end
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] ir, input logic [15:0] a, input logic [15:0] b);
        if (r == 0) begin
            bus.req0 = v; bus.ir0 = ir; bus.a0 = a; bus.b0 = b;
        end else begin
            bus.req1 = v; bus.ir1 = ir; bus.a1 = a; bus.b1 = b;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", bus.ack); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if ({bus.alu_start, bus.alu_oe} !== 2'b00) begin errors++; $display("FAIL reset_start_oe: got %b expected 00", {bus.alu_start, bus.alu_oe}); end
        checks++; if ({bus.alu_ir, bus.alu_a, bus.alu_b} !== 40'h0) begin errors++; $display("FAIL reset_alu_regs: got %h expected 0", {bus.alu_ir, bus.alu_a, bus.alu_b}); end
        checks++; if ({bus.rsp_data, bus.rsp_carry, bus.rsp_over, bus.rsp_err} !== 19'h0) begin errors++; $display("FAIL reset_rsp: got %h expected 0", {bus.rsp_data, bus.rsp_carry, bus.rsp_over, bus.rsp_err}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_contention();
        logic [1:0]  ackv;
        int          lat, ns, no;
        logic [17:0] r0, r1, want;
        cfg_h = 1; cfg_l = 2;
        r0 = alu_fn(8'h10, 16'd100, 16'd1);
        r1 = alu_fn(8'h21, 16'd50, 16'd60);
        @(negedge clk);
        set_req(0, 1'b1, 8'h10, 16'd100, 16'd1);
        set_req(1, 1'b1, 8'h21, 16'd50, 16'd60);
        for (int k = 0; k < 4; k++) begin
            wait_ack(ackv, lat, ns, no);
            want = (k % 2 == 0) ? r0 : r1;
            checks++; if (ackv !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL contention_ack[%0d]: got %b expected %b", k, ackv, (k % 2 == 0) ? 2'b01 : 2'b10); end
            checks++; if (lat !== 7) begin errors++; $display("FAIL contention_latency[%0d]: got %0d expected 7", k, lat); end
            checks++; if ({bus.rsp_over, bus.rsp_carry, bus.rsp_data} !== want) begin errors++; $display("FAIL contention_result[%0d]: got %h expected %h", k, {bus.rsp_over, bus.rsp_carry, bus.rsp_data}, want); end
            @(negedge clk);
            checks++; if ({bus.ack, bus.busy} !== 3'b000) begin errors++; $display("FAIL contention_idle[%0d]: ack/busy got %b expected 000", k, {bus.ack, bus.busy}); end
            if (k == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
        end
    endtask

    task automatic test_single_request();
        logic [1:0] ackv;
        int         lat, ns, no;
        cfg_h = 0; cfg_l = 4;
        @(negedge clk);
        set_req(0, 1'b1, 8'h10, 16'd5, 16'd3);
        wait_ack(ackv, lat, ns, no);
        checks++; if (ackv !== 2'b01) begin errors++; $display("FAIL single_ack: got %b expected 01", ackv); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL single_latency: got %0d expected 8", lat); end
        checks++; if (ns !== 1) begin errors++; $display("FAIL single_start_cycles: got %0d expected 1", ns); end
        checks++; if (no !== 1) begin errors++; $display("FAIL single_oe_cycles: got %0d expected 1", no); end
        checks++; if (bus.rsp_data !== 16'd8) begin errors++; $display("FAIL single_data: got %0d expected 8", bus.rsp_data); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", bus.rsp_err); end
        checks++; if ({bus.alu_ir, bus.alu_a, bus.alu_b} !== {8'h10, 16'd5, 16'd3}) begin errors++; $display("FAIL single_alu_regs: got %h expected 10_0005_0003", {bus.alu_ir, bus.alu_a, bus.alu_b}); end
        @(negedge clk);
        bus.req0 = 1'b0;
        checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL single_ack_pulse: got %b expected 00", bus.ack); end
    endtask

    task automatic test_flags();
        logic [1:0] ackv;
        int         lat, ns, no;
        cfg_h = 2; cfg_l = 3;
        @(negedge clk);
        set_req(0, 1'b1, 8'h10, 16'h8000, 16'h8000);
        wait_ack(ackv, lat, ns, no);
        checks++; if (lat !== 9) begin errors++; $display("FAIL flags_latency: got %0d expected 9", lat); end
        checks++; if ({bus.rsp_carry, bus.rsp_over, bus.rsp_data} !== {1'b1, 1'b1, 16'h0000}) begin errors++; $display("FAIL flags_result: got %h expected 3_0000", {bus.rsp_carry, bus.rsp_over, bus.rsp_data}); end
        @(negedge clk);
        bus.req0 = 1'b0;
    endtask

    task automatic test_operand_stability();
        logic [1:0] ackv;
        int         lat, ns, no;
        cfg_h = 0; cfg_l = 6;
        @(negedge clk);
        set_req(0, 1'b1, 8'h10, 16'd5, 16'd7);
        repeat (4) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stability_busy: got %b expected 1", bus.busy); end
        bus.a0  = 16'd9;
        bus.ir0 = 8'h25;
        bus.req1 = 1'b1;
        wait_ack(ackv, lat, ns, no);
        checks++; if (ackv !== 2'b01) begin errors++; $display("FAIL stability_ack: got %b expected 01", ackv); end
        checks++; if (lat !== 6) begin errors++; $display("FAIL stability_latency: got %0d expected 6", lat); end
        checks++; if (bus.alu_a !== 16'd5) begin errors++; $display("FAIL stability_alu_a: got %0d expected 5", bus.alu_a); end
        checks++; if (bus.rsp_data !== 16'd12) begin errors++; $display("FAIL stability_data: got %0d expected 12", bus.rsp_data); end
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic test_timeout();
        logic [1:0] ackv;
        int         lat, ns, no;
        // establish a known prior result
        cfg_h = 0; cfg_l = 1;
        @(negedge clk);
        set_req(0, 1'b1, 8'h10, 16'h1234, 16'h0101);
        wait_ack(ackv, lat, ns, no);
        checks++; if (bus.rsp_data !== 16'h1335) begin errors++; $display("FAIL timeout_prior_data: got %h expected 1335", bus.rsp_data); end
        // done never drops: WAIT_LO gives up after TO cycles
        @(negedge clk);
        cfg_h = 1000; cfg_l = 1;
        set_req(0, 1'b1, 8'h10, 16'h7777, 16'h0001);
        wait_ack(ackv, lat, ns, no);
        checks++; if (ackv !== 2'b01) begin errors++; $display("FAIL timeout_lo_ack: got %b expected 01", ackv); end
        checks++; if (lat !== TO + 2) begin errors++; $display("FAIL timeout_lo_latency: got %0d expected %0d", lat, TO + 2); end
        checks++; if (bus.rsp_err !== 1'b1) begin errors++; $display("FAIL timeout_lo_err: got %b expected 1", bus.rsp_err); end
        checks++; if (bus.rsp_data !== 16'h1335) begin errors++; $display("FAIL timeout_lo_data: got %h expected 1335", bus.rsp_data); end
        checks++; if (no !== 0) begin errors++; $display("FAIL timeout_lo_oe: got %0d cycles expected 0", no); end
        // done drops but never rises: WAIT_HI gives up
        @(negedge clk);
        bus.req0 = 1'b0;
        cfg_h = 2; cfg_l = 1000;
        set_req(1, 1'b1, 8'h10, 16'h0f0f, 16'h0101);
        wait_ack(ackv, lat, ns, no);
        checks++; if (ackv !== 2'b10) begin errors++; $display("FAIL timeout_hi_ack: got %b expected 10", ackv); end
        checks++; if (lat !== 2 + TO + 3) begin errors++; $display("FAIL timeout_hi_latency: got %0d expected %0d", lat, 2 + TO + 3); end
        checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b1, 16'h1335}) begin errors++; $display("FAIL timeout_hi_rsp: got %h expected 1_1335", {bus.rsp_err, bus.rsp_data}); end
        // a normal operation clears the error
        @(negedge clk);
        bus.req1 = 1'b0;
        cfg_h = 0; cfg_l = 2;
        set_req(0, 1'b1, 8'h10, 16'd20, 16'd22);
        wait_ack(ackv, lat, ns, no);
        checks++; if ({bus.rsp_err, bus.rsp_data} !== {1'b0, 16'd42}) begin errors++; $display("FAIL timeout_recover: got %h expected 0_002a", {bus.rsp_err, bus.rsp_data}); end
        @(negedge clk);
        bus.req0 = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [1:0]  ackv;
        int          lat, ns, no, pulses;
        logic [17:0] want;
        cfg_h = 0; cfg_l = 10;
        @(negedge clk);
        set_req(0, 1'b1, 8'h10, 16'hABCD, 16'h0001);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
        checks++; if ({bus.ack, bus.alu_start, bus.alu_oe, bus.alu_a} !== 20'h0) begin errors++; $display("FAIL midreset_outputs: got %h expected 0", {bus.ack, bus.alu_start, bus.alu_oe, bus.alu_a}); end
        bus.req0 = 1'b0;
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (n == 2) rst = 1'b0;
            if (bus.ack !== 2'b00) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midreset_no_ack: got %0d pulses expected 0", pulses); end
        cfg_h = 1; cfg_l = 2;
        want = alu_fn(8'h21, 16'd300, 16'd45);
        set_req(1, 1'b1, 8'h21, 16'd300, 16'd45);
        wait_ack(ackv, lat, ns, no);
        checks++; if (ackv !== 2'b10) begin errors++; $display("FAIL midreset_req1_ack: got %b expected 10", ackv); end
        checks++; if (lat !== 7) begin errors++; $display("FAIL midreset_req1_latency: got %0d expected 7", lat); end
        checks++; if ({bus.rsp_over, bus.rsp_carry, bus.rsp_data} !== want) begin errors++; $display("FAIL midreset_req1_result: got %h expected %h", {bus.rsp_over, bus.rsp_carry, bus.rsp_data}, want); end
        @(negedge clk);
        bus.req1 = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0]  rir [2];
        logic [15:0] ra  [2];
        logic [15:0] rb  [2];
        bit          pend [2];
        int          mdl_last, w, h, l, elat, lat, ns, no;
        bit          to;
        logic [17:0] mdl_res;
        logic [1:0]  ackv;
        apply_reset();
        mdl_last = 1;
        mdl_res  = '0;
        pend[0] = 0; pend[1] = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL rand_ack_pulse[%0d]: got %b expected 00", i, bus.ack); end
            end
            // new arrivals on idle requesters; a pending loser keeps its operands
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) == 1)) pend[r] = 1;
                else if (!pend[r]) set_req(r, 1'b0, 8'h00, 16'h0, 16'h0);
            end
            if (!pend[0] && !pend[1]) pend[$urandom_range(0, 1)] = 1;
            for (int r = 0; r < 2; r++) begin
                if (pend[r] && ((r == 0) ? (bus.req0 !== 1'b1) : (bus.req1 !== 1'b1))) begin
                    rir[r] = ($urandom_range(0, 3) == 0) ? 8'h50 + 8'($urandom_range(0, 4)) : 8'($urandom);
                    ra[r]  = 16'($urandom);
                    rb[r]  = 16'($urandom);
                    set_req(r, 1'b1, rir[r], ra[r], rb[r]);
                end
            end
            case ($urandom_range(0, 9))
                0:       begin h = $urandom_range(TO, TO + 10); l = 1; end
                1:       begin h = $urandom_range(0, 3); l = $urandom_range(TO + 1, TO + 10); end
                default: begin h = $urandom_range(0, 4); l = $urandom_range(1, 5); end
            endcase
            cfg_h = h; cfg_l = l;
            // reference: round robin on the last served requester, latency from the done phases
            if (pend[0] && pend[1]) w = 1 - mdl_last;
            else w = pend[1] ? 1 : 0;
            mdl_last = w;
            if (h >= TO) begin to = 1; elat = TO + 2; end
            else if (l >= TO + 1) begin to = 1; elat = h + TO + 3; end
            else begin to = 0; elat = h + l + 4; mdl_res = alu_fn(rir[w], ra[w], rb[w]); end
            wait_ack(ackv, lat, ns, no);
            checks++; if (ackv !== ((w == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rand_ack[%0d]: got %b expected %b", i, ackv, (w == 1) ? 2'b10 : 2'b01); end
            checks++; if (lat !== elat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, elat); end
            checks++; if (bus.rsp_err !== to) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", i, bus.rsp_err, to); end
            checks++; if ({bus.rsp_over, bus.rsp_carry, bus.rsp_data} !== mdl_res) begin errors++; $display("FAIL rand_result[%0d]: got %h expected %h", i, {bus.rsp_over, bus.rsp_carry, bus.rsp_data}, mdl_res); end
            checks++; if ({ns, no} !== {32'd1, to ? 32'd0 : 32'd1}) begin errors++; $display("FAIL rand_strobes[%0d]: start/oe got %0d/%0d expected 1/%0d", i, ns, no, to ? 0 : 1); end
            pend[w] = 0;
            if (w == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
        end
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_req(0, 1'b0, 8'h00, 16'h0, 16'h0);
        set_req(1, 1'b0, 8'h00, 16'h0, 16'h0);
        test_reset();
        test_contention();
        test_single_request();
        test_flags();
        test_operand_stability();
        test_timeout();
        test_reset_mid_op();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: maximum cycles spent waiting on either alu_done edge before aborting.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0 / req1  input  1 each  request level from requester 0 / 1; held high until that requester's ack.
REQ-005 ir0 / ir1  input  8 each  ALU instruction per requester; stable while the request is high.
REQ-006 a0, b0 / a1, b1  input  16 each  operands per requester; stable while the request is high.
REQ-007 ack  output  2  one-hot completion pulse, bit n for requester n.
REQ-008 rsp_data  output  16  captured ALU result.
REQ-009 rsp_carry / rsp_over  output  1 each  captured ALU carry / overflow.
REQ-010 rsp_err  output  1  timeout indication, valid with ack.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 alu_start  output  1  start to ALU.
REQ-013 alu_ir  output  8  latched instruction to ALU.
REQ-014 alu_a / alu_b  output  16 each  latched operands to ALU.
REQ-015 alu_oe  output  1  ALU output enable.
REQ-016 alu_done  input  1  ALU done: high when idle, low while an operation runs.
REQ-017 alu_out  input  16  ALU result.
REQ-018 alu_carry / alu_over  input  1 each  ALU flags.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT_LO, WAIT_HI, CAPTURE, RESP.
REQ-020 IDLE: if any req high, select winner, latch its ir/a/b into alu_ir/alu_a/alu_b and owner register, go to ISSUE; else stay.
REQ-021 Arbitration round-robin on last_grant (reset 1): both requesting -> grant requester != last_grant; one requesting -> grant it unconditionally.
REQ-022 last_grant updated to the owner on entry to ISSUE.
REQ-023 ISSUE: alu_start=1 for exactly this one cycle; clear timer; go to WAIT_LO.
REQ-024 WAIT_LO: alu_done=0 -> clear timer, go to WAIT_HI; else increment timer.
REQ-025 WAIT_HI: alu_done=1 -> go to CAPTURE; else increment timer.
REQ-026 In WAIT_LO or WAIT_HI, timer reaching TIMEOUT-1 with no exit condition -> set err flag, go to RESP without capture.
REQ-027 CAPTURE: alu_oe=1; latch alu_out, alu_carry, alu_over into rsp_data, rsp_carry, rsp_over; clear err; go to RESP.
REQ-028 alu_oe SHALL be 0 in every state except CAPTURE.
REQ-029 RESP: ack[owner]=1 for exactly one cycle; rsp_err=err; go to IDLE.
REQ-030 rsp_data/rsp_carry/rsp_over hold their values until the next CAPTURE; on timeout they keep the prior values.
REQ-031 Latency with no timeout: ack 4 + (cycles alu_done stays high after start) + (cycles alu_done stays low) cycles after grant.
REQ-032 Minimum turnaround: a request may be granted in the IDLE cycle immediately after RESP.
REQ-033 Requests arriving, or a req deasserted, while busy SHALL NOT affect the operation in flight; latched operands are used.
REQ-034 Instruction values pass through unmodified, including mode-setting instructions (0x50-0x54); completion still follows REQ-024/025, else timeout.
REQ-035 Timer 8 bits wide minimum, saturating; SHALL NOT wrap.

Reset
REQ-036 On rst, immediately: state IDLE; last_grant=1; owner=0; timer=0; err=0.
REQ-037 On rst, outputs: ack=0, busy=0, alu_start=0, alu_oe=0, alu_ir=0, alu_a=0, alu_b=0, rsp_data=0, rsp_carry=0, rsp_over=0, rsp_err=0.
REQ-038 rst mid-operation aborts without ack; the first request after release restarts arbitration with requester 0 favoured.

Verification
REQ-039 Single request: req0, ir0=0x10, a0=5, b0=3; ALU model holds done low 4 cycles, outputs 8 -> one-cycle alu_start, alu_oe high one cycle, ack=01, rsp_data=8, rsp_err=0.
REQ-040 Contention: req0 and req1 high from reset -> grants ordered 0,1,0,1 over four operations; ack alternates 01,10,01,10.
REQ-041 Timeout: alu_done held high after start, TIMEOUT=64 -> ack after 64 WAIT_LO cycles; rsp_err=1; rsp_data keeps previous value; alu_oe never high.
REQ-042 Operand stability: change a0 from 5 to 9 during WAIT_HI -> alu_a stays 5; result unaffected.
REQ-043 Flags: ALU model returns 0x0000 with carry=1, over=1 -> rsp_carry=1, rsp_over=1, rsp_data=0.
REQ-044 Reset in WAIT_HI -> ack never pulses; busy=0 immediately; next req1 alone is granted and completes normally.
